// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - shared FSM encodings, glyph constants and widths for the output-port display
package seg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CONV   = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

  // 32 input bits -> 5-bit step counter
  localparam int BIT_CNT_W = 5;

  // Active-low glyphs, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] GLYPH_0     = 7'b1000000;
  localparam logic [6:0] GLYPH_1     = 7'b1111001;
  localparam logic [6:0] GLYPH_2     = 7'b0100100;
  localparam logic [6:0] GLYPH_3     = 7'b0110000;
  localparam logic [6:0] GLYPH_4     = 7'b0011001;
  localparam logic [6:0] GLYPH_5     = 7'b0010010;
  localparam logic [6:0] GLYPH_6     = 7'b0000010;
  localparam logic [6:0] GLYPH_7     = 7'b1111000;
  localparam logic [6:0] GLYPH_8     = 7'b0000000;
  localparam logic [6:0] GLYPH_9     = 7'b0010000;
  localparam logic [6:0] GLYPH_DASH  = 7'b0111111;
  localparam logic [6:0] GLYPH_BLANK = 7'b1111111;

  function automatic logic [6:0] digit_glyph(input logic [3:0] nib);
    case (nib)
      4'd0:    digit_glyph = GLYPH_0;
      4'd1:    digit_glyph = GLYPH_1;
      4'd2:    digit_glyph = GLYPH_2;
      4'd3:    digit_glyph = GLYPH_3;
      4'd4:    digit_glyph = GLYPH_4;
      4'd5:    digit_glyph = GLYPH_5;
      4'd6:    digit_glyph = GLYPH_6;
      4'd7:    digit_glyph = GLYPH_7;
      4'd8:    digit_glyph = GLYPH_8;
      4'd9:    digit_glyph = GLYPH_9;
      default: digit_glyph = GLYPH_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/out_port_seg_ctrl_if.sv
// rtl/out_port_seg_ctrl_if.sv - load handshake and display pins of the output-port display controller
interface out_port_seg_ctrl_if #(parameter int DIGITS = 8);
  logic [31:0]         data_in;
  logic                data_valid;
  logic                busy;
  logic                overflow;
  logic [4*DIGITS-1:0] bcd_out;
  logic [6:0]          seg_out;
  logic [DIGITS-1:0]   digit_sel;

  modport master (
    output data_in, data_valid,
    input  busy, overflow, bcd_out, seg_out, digit_sel
  );

  modport slave (
    input  data_in, data_valid,
    output busy, overflow, bcd_out, seg_out, digit_sel
  );
endinterface

// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - sequential double-dabble, one shift/add-3 step per clock
module bin2bcd_seq
  import seg_pkg::*;
#(
  parameter int DIGITS = 8
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                start,
  input  logic [31:0]         din,
  output logic                done,
  output logic [4*DIGITS-1:0] bcd,
  output logic                ovf
);
  localparam int BW = 4 * DIGITS;

  logic [31:0]          sh;
  logic [BIT_CNT_W-1:0] cnt;
  logic                 active;
  logic [BW-1:0]        adj;

  always_comb begin
    adj = bcd;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
  end

  // done is registered so the caller sees it one cycle after the final step
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sh     <= '0;
      bcd    <= '0;
      ovf    <= 1'b0;
      cnt    <= '0;
      active <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        sh     <= din;
        bcd    <= '0;
        ovf    <= 1'b0;
        cnt    <= '0;
        active <= 1'b1;
      end else if (active) begin
        bcd <= {adj[BW-2:0], sh[31]};
        sh  <= {sh[30:0], 1'b0};
        if (adj[BW-1]) ovf <= 1'b1;
        if (cnt == {BIT_CNT_W{1'b1}}) begin
          active <= 1'b0;
          done   <= 1'b1;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end
endmodule

// File: rtl/out_port_seg_ctrl.sv
// rtl/out_port_seg_ctrl.sv - CPU output-port display: load FSM, pending slot, BCD commit and digit scanner
module out_port_seg_ctrl
  import seg_pkg::*;
#(
  parameter int DIGITS   = 8,
  parameter int SCAN_DIV = 50000,
  parameter int BLANK_LZ = 1
) (
  input  logic              clk,
  input  logic              resetn,
  out_port_seg_ctrl_if.slave bus
);
  localparam int BW     = 4 * DIGITS;
  localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  state_t        state, state_nxt;
  logic          start, commit;
  logic [31:0]   load_val;
  logic          conv_done, conv_ovf;
  logic [BW-1:0] conv_bcd;
  logic          pending;
  logic [31:0]   pend_data;
  logic [BW-1:0] bcd_q;
  logic          ovf_q;

  bin2bcd_seq #(.DIGITS(DIGITS)) u_conv (
    .clk    (clk),
    .resetn (resetn),
    .start  (start),
    .din    (load_val),
    .done   (conv_done),
    .bcd    (conv_bcd),
    .ovf    (conv_ovf)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  // A load arriving during COMMIT is the newest writer, so it goes straight in
  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    commit    = 1'b0;
    load_val  = bus.data_in;
    case (state)
      ST_IDLE: begin
        if (bus.data_valid) begin
          start     = 1'b1;
          state_nxt = ST_CONV;
        end
      end
      ST_CONV: begin
        if (conv_done) state_nxt = ST_COMMIT;
      end
      ST_COMMIT: begin
        commit = 1'b1;
        if (bus.data_valid || pending) begin
          start     = 1'b1;
          load_val  = bus.data_valid ? bus.data_in : pend_data;
          state_nxt = ST_CONV;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pending   <= 1'b0;
      pend_data <= '0;
      bcd_q     <= '0;
      ovf_q     <= 1'b0;
    end else begin
      if (state == ST_CONV && bus.data_valid) begin
        pending   <= 1'b1;
        pend_data <= bus.data_in;
      end else if (state == ST_COMMIT) begin
        pending <= 1'b0;
      end
      if (commit) begin
        bcd_q <= conv_bcd;
        ovf_q <= conv_ovf;
      end
    end
  end

  assign bus.busy     = (state != ST_IDLE) | pending;
  assign bus.bcd_out  = bcd_q;
  assign bus.overflow = ovf_q;

  logic [SCAN_W-1:0] scan_cnt;
  logic [IDX_W-1:0]  digit_idx;
  logic [BW-1:0]     upper;
  logic              blank;
  logic [6:0]        glyph;
  logic [6:0]        seg_q;
  logic [DIGITS-1:0] sel_q;

  // upper holds the selected nibble and everything above it
  always_comb begin
    upper = bcd_q >> {digit_idx, 2'b00};
    blank = (BLANK_LZ != 0) && (digit_idx != '0) && (upper == '0);
    if (ovf_q)      glyph = GLYPH_DASH;
    else if (blank) glyph = GLYPH_BLANK;
    else            glyph = digit_glyph(upper[3:0]);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      scan_cnt  <= '0;
      digit_idx <= '0;
      seg_q     <= GLYPH_BLANK;
      sel_q     <= '1;
    end else begin
      if (scan_cnt == SCAN_W'(SCAN_DIV - 1)) begin
        scan_cnt  <= '0;
        digit_idx <= (digit_idx == IDX_W'(DIGITS - 1)) ? '0 : digit_idx + 1'b1;
      end else begin
        scan_cnt <= scan_cnt + 1'b1;
      end
      seg_q <= glyph;
      sel_q <= ~(DIGITS'(1) << digit_idx);
    end
  end

  assign bus.seg_out   = seg_q;
  assign bus.digit_sel = sel_q;
endmodule

// File: tb/tb_out_port_seg_ctrl.sv
// tb/tb_out_port_seg_ctrl.sv - directed self-checking bench for out_port_seg_ctrl
module tb_out_port_seg_ctrl;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  out_port_seg_ctrl_if #(.DIGITS(8)) bus ();
  out_port_seg_ctrl_if #(.DIGITS(8)) bus2 ();

  out_port_seg_ctrl #(.DIGITS(8), .SCAN_DIV(4), .BLANK_LZ(1)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  out_port_seg_ctrl #(.DIGITS(8), .SCAN_DIV(4), .BLANK_LZ(0)) dut_nolz (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus2)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [31:0] v);
    bus.data_in    = v;
    bus.data_valid = 1'b1;
    tick();
    bus.data_valid = 1'b0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (bus.busy === 1'b1 && n < 300) begin
      n++;
      tick();
    end
  endtask

  task automatic seg_at(input int which, input int d, output logic [6:0] seg);
    logic [7:0] want;
    logic [7:0] sel;
    want = ~(8'd1 << d);
    seg  = 'x;
    for (int k = 0; k < 64; k++) begin
      sel = (which != 0) ? bus2.digit_sel : bus.digit_sel;
      if (sel == want) begin
        seg = (which != 0) ? bus2.seg_out : bus.seg_out;
        return;
      end
      tick();
    end
    check("scan_timeout", 32'd0, 32'd1);
  endtask

  int           n;
  logic [6:0]   sg;
  int           busy_cnt;
  int           first_low;
  logic [31:0]  last;
  logic [31:0]  changes[$];
  logic         saw7;

  initial begin
    bus.data_in = '0;  bus.data_valid = 1'b0;
    bus2.data_in = '0; bus2.data_valid = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_bcd", bus.bcd_out, 32'h0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_ovf", 32'(bus.overflow), 32'd0);
    check("rst_seg", 32'(bus.seg_out), 32'h7F);
    check("rst_sel", 32'(bus.digit_sel), 32'hFF);

    resetn = 1'b1;
    for (int d = 0; d < 8; d++) begin
      for (int k = 0; k < 4; k++) begin
        tick();
        check($sformatf("idle_sel_d%0d_k%0d", d, k), 32'(bus.digit_sel), 32'(8'(~(8'd1 << d))));
        check($sformatf("idle_seg_d%0d_k%0d", d, k), 32'(bus.seg_out), (d == 0) ? 32'h40 : 32'h7F);
      end
    end
    check("idle_bcd", bus.bcd_out, 32'h0);
    check("idle_busy", 32'(bus.busy), 32'd0);

    load(32'd12345678);
    wait_idle(n);
    check("busy_cycles_12345678", 32'(n), 32'd34);
    check("bcd_12345678", bus.bcd_out, 32'h12345678);
    check("ovf_12345678", 32'(bus.overflow), 32'd0);
    tick();
    seg_at(0, 0, sg); check("seg_d0_8", 32'(sg), 32'h00);
    seg_at(0, 3, sg); check("seg_d3_5", 32'(sg), 32'h12);
    seg_at(0, 7, sg); check("seg_d7_1", 32'(sg), 32'h79);

    load(32'd100000000);
    wait_idle(n);
    check("busy_cycles_1e8", 32'(n), 32'd34);
    check("ovf_1e8", 32'(bus.overflow), 32'd1);
    tick();
    for (int d = 0; d < 8; d++) begin
      seg_at(0, d, sg);
      check($sformatf("dash_d%0d", d), 32'(sg), 32'h3F);
    end

    load(32'd99999999);
    wait_idle(n);
    check("ovf_99999999", 32'(bus.overflow), 32'd0);
    check("bcd_99999999", bus.bcd_out, 32'h99999999);
    tick();
    seg_at(0, 7, sg); check("seg_d7_9", 32'(sg), 32'h10);

    load(32'd42);
    busy_cnt  = 0;
    first_low = -1;
    last      = bus.bcd_out;
    saw7      = 1'b0;
    for (int cyc = 0; cyc < 80; cyc++) begin
      if (bus.busy === 1'b1) busy_cnt++;
      else if (first_low < 0) first_low = cyc;
      if (bus.bcd_out !== last) begin
        changes.push_back(bus.bcd_out);
        last = bus.bcd_out;
      end
      if (bus.bcd_out == 32'h7) saw7 = 1'b1;
      bus.data_valid = (cyc == 9 || cyc == 19);
      bus.data_in    = (cyc == 9) ? 32'd7 : 32'd9;
      tick();
    end
    bus.data_valid = 1'b0;
    check("pend_busy_cycles", 32'(busy_cnt), 32'd68);
    check("pend_first_low", 32'(first_low), 32'd68);
    check("pend_num_commits", 32'(changes.size()), 32'd2);
    if (changes.size() == 2) begin
      check("pend_commit0", changes[0], 32'h42);
      check("pend_commit1", changes[1], 32'h9);
    end
    check("pend_no7", 32'(saw7), 32'd0);

    load(32'd555);
    repeat (14) tick();
    resetn = 1'b0;
    #1;
    check("arst_bcd", bus.bcd_out, 32'h0);
    check("arst_busy", 32'(bus.busy), 32'd0);
    check("arst_ovf", 32'(bus.overflow), 32'd0);
    check("arst_seg", 32'(bus.seg_out), 32'h7F);
    check("arst_sel", 32'(bus.digit_sel), 32'hFF);
    tick();
    tick();
    resetn = 1'b1;
    repeat (40) tick();
    check("post_rst_bcd", bus.bcd_out, 32'h0);
    check("post_rst_busy", 32'(bus.busy), 32'd0);

    bus2.data_in    = 32'd7;
    bus2.data_valid = 1'b1;
    tick();
    bus2.data_valid = 1'b0;
    n = 0;
    while (bus2.busy === 1'b1 && n < 300) begin
      n++;
      tick();
    end
    check("nolz_busy_cycles", 32'(n), 32'd34);
    check("nolz_bcd", bus2.bcd_out, 32'h00000007);
    tick();
    seg_at(1, 0, sg); check("nolz_d0_7", 32'(sg), 32'h78);
    for (int d = 1; d < 8; d++) begin
      seg_at(1, d, sg);
      check($sformatf("nolz_d%0d_0", d), 32'(sg), 32'h40);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
